rpn_stack_calc: RTL and testbench

RPN_STACK_CALC -- requirements
Module: rpn_stack_calc

---
 rtl/rpn_stack_calc.sv | 211 +++++++++++++++++++++
 tb/tb_rpn_stack_calc.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_calc.sv
// RPN stack calculator: register-array operand stack with single-cycle ALU ops and a W-cycle restoring divider.
// Define RPN_STACK_CALC_SAT_EN to make ADD/SUB/MUL saturate instead of wrapping.
module rpn_stack_calc #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       apply,
  input  logic [2:0]                 op,
  input  logic [W-1:0]               in,
  output logic                       ready,
  output logic [W-1:0]               top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic [2:0]                 err,
  output logic                       valid
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ITW = $clog2(W);

  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
  localparam logic [ITW-1:0] IT_LAST  = ITW'(W - 1);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_MOD  = 3'd4;
  localparam logic [2:0] OP_PUSH = 3'd5;
  localparam logic [2:0] OP_POP  = 3'd6;
  localparam logic [2:0] OP_DUP  = 3'd7;

  typedef enum logic {S_IDLE, S_DIV} state_t;

  function automatic logic [W-1:0] f_add(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef RPN_STACK_CALC_SAT_EN
    return (b > ~a) ? '1 : a + b;
`else
    return a + b;
`endif
  endfunction

  function automatic logic [W-1:0] f_sub(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef RPN_STACK_CALC_SAT_EN
    return (a < b) ? '0 : a - b;
`else
    return a - b;
`endif
  endfunction

  function automatic logic [W-1:0] f_mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef RPN_STACK_CALC_SAT_EN
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return (|p[2*W-1:W]) ? '1 : p[W-1:0];
`else
    return a * b;
`endif
  endfunction

  state_t         r_state;
  logic           r_ready;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_err;
  logic [ITW-1:0] r_it;

  logic [W-1:0]   r_stack [0:DEPTH-1];
  logic [W-1:0]   r_quo;
  logic [W-1:0]   r_rem;
  logic [W-1:0]   r_div;
  logic           r_mod;

  logic [CW-1:0]  w_cm1;
  logic [CW-1:0]  w_cm2;
  logic [AW-1:0]  w_idx_push;
  logic [AW-1:0]  w_idx_top;
  logic [AW-1:0]  w_idx_nos;
  logic [W-1:0]   w_tos;
  logic [W-1:0]   w_nos;
  logic [W-1:0]   w_alu;
  logic           w_full;
  logic           w_acc;
  logic           w_is_bin;
  logic           w_is_div;
  logic           w_uf;
  logic           w_of;
  logic           w_dz;
  logic           w_ok;
  logic           w_push;
  logic           w_dup;
  logic           w_pop;
  logic           w_alu_wr;
  logic           w_div_go;
  logic           w_div_done;
  logic [W:0]     w_shift;
  logic           w_ge;
  logic [W-1:0]   w_rem_nx;
  logic [W-1:0]   w_quo_nx;

  always_comb begin
    w_cm1      = r_cnt - CW'(1);
    w_cm2      = r_cnt - CW'(2);
    w_idx_push = r_cnt[AW-1:0];
    w_idx_top  = w_cm1[AW-1:0];
    w_idx_nos  = w_cm2[AW-1:0];
    w_tos      = r_stack[w_idx_top];
    w_nos      = r_stack[w_idx_nos];
    w_full     = (r_cnt == FULL_CNT);

    w_alu = '0;
    case (op)
      OP_ADD:  w_alu = f_add(w_nos, w_tos);
      OP_SUB:  w_alu = f_sub(w_nos, w_tos);
      OP_MUL:  w_alu = f_mul(w_nos, w_tos);
      default: w_alu = '0;
    endcase

    // Error classification is exclusive: underflow first, then overflow / divide-by-zero.
    w_acc    = apply && r_ready && !rst;
    w_is_bin = (op <= OP_MOD);
    w_is_div = (op == OP_DIV) || (op == OP_MOD);
    w_uf     = w_acc && ((w_is_bin && (r_cnt < CW'(2))) ||
                         (((op == OP_POP) || (op == OP_DUP)) && (r_cnt == '0)));
    w_of     = w_acc && !w_uf && ((op == OP_PUSH) || (op == OP_DUP)) && w_full;
    w_dz     = w_acc && !w_uf && w_is_div && (w_tos == '0);
    w_ok     = w_acc && !w_uf && !w_of && !w_dz;
    w_push   = w_ok && (op == OP_PUSH);
    w_dup    = w_ok && (op == OP_DUP);
    w_pop    = w_ok && (op == OP_POP);
    w_alu_wr = w_ok && w_is_bin && !w_is_div;
    w_div_go = w_ok && w_is_div;

    w_div_done = (r_state == S_DIV) && (r_it == IT_LAST) && !rst;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    w_shift  = {r_rem, r_quo[W-1]};
    w_ge     = (w_shift >= {1'b0, r_div});
    w_rem_nx = w_ge ? W'(w_shift - {1'b0, r_div}) : w_shift[W-1:0];
    w_quo_nx = {r_quo[W-2:0], w_ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_cnt   <= '0;
      r_err   <= '0;
      r_it    <= '0;
    end else begin
      if (w_dz) r_err[0] <= 1'b1;
      if (w_uf) r_err[1] <= 1'b1;
      if (w_of) r_err[2] <= 1'b1;

      if (w_push || w_dup)
        r_cnt <= r_cnt + CW'(1);
      else if (w_pop || w_alu_wr || w_div_done)
        r_cnt <= w_cm1;

      case (r_state)
        S_IDLE: begin
          if (w_div_go) begin
            r_state <= S_DIV;
            r_ready <= 1'b0;
            r_it    <= '0;
          end
        end
        S_DIV: begin
          r_it <= r_it + ITW'(1);
          if (w_div_done) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)     r_stack[w_idx_push] <= in;
    if (w_dup)      r_stack[w_idx_push] <= w_tos;
    if (w_alu_wr)   r_stack[w_idx_nos]  <= w_alu;
    if (w_div_done) r_stack[w_idx_nos]  <= r_mod ? w_rem_nx : w_quo_nx;

    if (w_div_go) begin
      r_quo <= w_nos;
      r_div <= w_tos;
      r_rem <= '0;
      r_mod <= (op == OP_MOD);
    end else if (r_state == S_DIV) begin
      r_quo <= w_quo_nx;
      r_rem <= w_rem_nx;
    end
  end

  assign ready = r_ready;
  assign top   = (r_cnt == '0) ? '0 : w_tos;
  assign count = r_cnt;
  assign empty = (r_cnt == '0);
  assign full  = w_full;
  assign err   = r_err;
  assign valid = ~|r_err;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Bench for rpn_stack_calc (W=8, DEPTH=4): directed scenarios plus random commands against a queue model.
module tb_rpn_stack_calc;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       apply;
  logic [2:0] op;
  logic [7:0] t_in;
  logic       ready;
  logic [7:0] top;
  logic [2:0] count;
  logic       empty;
  logic       full;
  logic [2:0] err;
  logic       valid;

  rpn_stack_calc #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .apply(apply), .op(op), .in(t_in),
    .ready(ready), .top(top), .count(count), .empty(empty),
    .full(full), .err(err), .valid(valid)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int q[$];
  logic [2:0] m_err;

  function automatic int m_arith(input logic [2:0] o, input int a, input int b);
    int r;
    case (o)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a * b;
      3'd3:    r = a / b;
      default: r = a % b;
    endcase
`ifdef RPN_STACK_CALC_SAT_EN
    if (r > 255) r = 255;
    if (r < 0) r = 0;
`else
    r = r & 255;
`endif
    return r;
  endfunction

  function automatic void m_apply(input logic [2:0] o, input logic [7:0] v);
    int n, a, b;
    n = q.size();
    case (o)
      3'd5: if (n == DEPTH) m_err[2] = 1'b1; else q.push_back(int'(v));
      3'd6: if (n == 0) m_err[1] = 1'b1; else void'(q.pop_back());
      3'd7: begin
        if (n == 0) m_err[1] = 1'b1;
        else if (n == DEPTH) m_err[2] = 1'b1;
        else q.push_back(q[n-1]);
      end
      default: begin
        if (n < 2) m_err[1] = 1'b1;
        else if ((o == 3'd3 || o == 3'd4) && q[n-1] == 0) m_err[0] = 1'b1;
        else begin
          b = q.pop_back();
          a = q.pop_back();
          q.push_back(m_arith(o, a, b));
        end
      end
    endcase
  endfunction

  function automatic int m_busy(input logic [2:0] o);
    if ((o == 3'd3 || o == 3'd4) && q.size() >= 2 && q[$] != 0) return W;
    return 0;
  endfunction

  function automatic logic [7:0] m_top();
    return (q.size() == 0) ? 8'd0 : 8'(q[$]);
  endfunction

  // Issue one command at a negedge, then wait (bounded) for ready, toggling junk commands while busy.
  task automatic drive(input logic [2:0] o, input logic [7:0] v, output int busy);
    apply = 1'b1; op = o; t_in = v;
    @(negedge clk);
    apply = 1'b0;
    busy = 0;
    while (ready !== 1'b1 && busy < 50) begin
      busy++;
      apply = 1'($urandom_range(0, 1));
      op    = 3'($urandom_range(0, 7));
      t_in  = 8'($urandom);
      @(negedge clk);
    end
    apply = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; apply = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_err = 3'b000;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; apply = 1'b1; op = 3'd5; t_in = 8'd42;
    @(negedge clk);
    apply = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (top !== 8'd0) begin n_fail++; $display("FAIL reset_top: got %0d want 0", top); end
    n_cmp++; if ({empty, full, valid, ready} !== 4'b1011) begin n_fail++; $display("FAIL reset_flags: got %b want 1011", {empty, full, valid, ready}); end
    n_cmp++; if (err !== 3'b000) begin n_fail++; $display("FAIL reset_err: got %b want 000", err); end
    q.delete(); m_err = 3'b000;
  endtask

  task automatic test_sub();
    int busy;
    do_reset();
    drive(3'd5, 8'd7, busy);
    n_cmp++; if (top !== 8'd7 || count !== 3'd1 || busy != 0) begin n_fail++; $display("FAIL sub_push7: top %0d cnt %0d busy %0d want 7 1 0", top, count, busy); end
    drive(3'd5, 8'd5, busy);
    n_cmp++; if (top !== 8'd5 || count !== 3'd2 || busy != 0) begin n_fail++; $display("FAIL sub_push5: top %0d cnt %0d busy %0d want 5 2 0", top, count, busy); end
    drive(3'd1, 8'd0, busy);
    n_cmp++; if (top !== 8'd2 || count !== 3'd1 || valid !== 1'b1 || busy != 0) begin n_fail++; $display("FAIL sub_result: top %0d cnt %0d valid %b busy %0d want 2 1 1 0", top, count, valid, busy); end
  endtask

  task automatic test_divmod();
    int busy, bad;
    do_reset();
    drive(3'd5, 8'd100, busy);
    drive(3'd5, 8'd7, busy);
    apply = 1'b1; op = 3'd3; t_in = 8'd0;
    @(negedge clk);
    apply = 1'b0;
    busy = 0; bad = 0;
    while (ready !== 1'b1 && busy < 50) begin
      busy++;
      if (top !== 8'd7 || count !== 3'd2) bad++;
      @(negedge clk);
    end
    n_cmp++; if (busy != 8) begin n_fail++; $display("FAIL div_busy: got %0d cycles want 8", busy); end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL div_hold: %0d busy cycles changed top/count, want 0", bad); end
    n_cmp++; if (top !== 8'd14 || count !== 3'd1 || ready !== 1'b1) begin n_fail++; $display("FAIL div_result: top %0d cnt %0d ready %b want 14 1 1", top, count, ready); end
    do_reset();
    drive(3'd5, 8'd100, busy);
    drive(3'd5, 8'd7, busy);
    drive(3'd4, 8'd0, busy);
    n_cmp++; if (busy != 8 || top !== 8'd2 || count !== 3'd1) begin n_fail++; $display("FAIL mod_result: busy %0d top %0d cnt %0d want 8 2 1", busy, top, count); end
  endtask

  task automatic test_arith();
    int busy;
    logic [7:0] e_add, e_sub, e_mul;
`ifdef RPN_STACK_CALC_SAT_EN
    e_add = 8'd255; e_sub = 8'd0; e_mul = 8'd255;
`else
    e_add = 8'd44; e_sub = 8'd254; e_mul = 8'd144;
`endif
    do_reset();
    drive(3'd5, 8'd200, busy);
    drive(3'd5, 8'd100, busy);
    drive(3'd0, 8'd0, busy);
    n_cmp++; if (top !== e_add || count !== 3'd1) begin n_fail++; $display("FAIL add_limit: top %0d cnt %0d want %0d 1", top, count, e_add); end
    drive(3'd5, 8'd3, busy);
    drive(3'd5, 8'd5, busy);
    drive(3'd1, 8'd0, busy);
    n_cmp++; if (top !== e_sub || count !== 3'd2) begin n_fail++; $display("FAIL sub_limit: top %0d cnt %0d want %0d 2", top, count, e_sub); end
    drive(3'd5, 8'd20, busy);
    drive(3'd5, 8'd20, busy);
    drive(3'd2, 8'd0, busy);
    n_cmp++; if (top !== e_mul || count !== 3'd3) begin n_fail++; $display("FAIL mul_limit: top %0d cnt %0d want %0d 3", top, count, e_mul); end
  endtask

  task automatic test_ovf_udf();
    int busy;
    do_reset();
    for (int i = 1; i <= 5; i++) drive(3'd5, 8'(i), busy);
    n_cmp++; if (err !== 3'b100 || count !== 3'd4 || top !== 8'd4 || full !== 1'b1) begin n_fail++; $display("FAIL overflow: err %b cnt %0d top %0d full %b want 100 4 4 1", err, count, top, full); end
    drive(3'd7, 8'd0, busy);
    n_cmp++; if (err !== 3'b100 || count !== 3'd4) begin n_fail++; $display("FAIL dup_full: err %b cnt %0d want 100 4", err, count); end
    for (int i = 0; i < 3; i++) drive(3'd6, 8'd0, busy);
    drive(3'd0, 8'd0, busy);
    n_cmp++; if (err !== 3'b110 || count !== 3'd1 || top !== 8'd1 || valid !== 1'b0) begin n_fail++; $display("FAIL underflow: err %b cnt %0d top %0d valid %b want 110 1 1 0", err, count, top, valid); end
    drive(3'd5, 8'd9, busy);
    n_cmp++; if (err !== 3'b110 || count !== 3'd2 || top !== 8'd9) begin n_fail++; $display("FAIL sticky_exec: err %b cnt %0d top %0d want 110 2 9", err, count, top); end
  endtask

  task automatic test_div0();
    int busy;
    do_reset();
    drive(3'd5, 8'd9, busy);
    drive(3'd5, 8'd0, busy);
    drive(3'd3, 8'd0, busy);
    n_cmp++; if (err !== 3'b001 || valid !== 1'b0 || count !== 3'd2 || top !== 8'd0 || ready !== 1'b1 || busy != 0) begin n_fail++; $display("FAIL div_zero: err %b valid %b cnt %0d top %0d ready %b busy %0d want 001 0 2 0 1 0", err, valid, count, top, ready, busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (err !== 3'b000 || valid !== 1'b1 || count !== 3'd0 || top !== 8'd0 || empty !== 1'b1 || ready !== 1'b1) begin n_fail++; $display("FAIL div_zero_rst: err %b valid %b cnt %0d top %0d empty %b ready %b want 000 1 0 0 1 1", err, valid, count, top, empty, ready); end
    q.delete(); m_err = 3'b000;
  endtask

  task automatic test_rst_during_div();
    int busy;
    do_reset();
    drive(3'd5, 8'd50, busy);
    drive(3'd5, 8'd3, busy);
    apply = 1'b1; op = 3'd3;
    @(negedge clk);
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rd_busy: ready %b want 0", ready); end
    apply = 1'b1; op = 3'd5; t_in = 8'd99;
    @(negedge clk);
    apply = 1'b0;
    n_cmp++; if (count !== 3'd2 || top !== 8'd3 || ready !== 1'b0) begin n_fail++; $display("FAIL rd_ignore: cnt %0d top %0d ready %b want 2 3 0", count, top, ready); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; apply = 1'b1; op = 3'd5; t_in = 8'd77;
    @(negedge clk);
    rst = 1'b0; apply = 1'b0;
    n_cmp++; if (count !== 3'd0 || ready !== 1'b1 || top !== 8'd0) begin n_fail++; $display("FAIL rd_abort: cnt %0d ready %b top %0d want 0 1 0", count, ready, top); end
    repeat (8) @(negedge clk);
    n_cmp++; if (count !== 3'd0 || ready !== 1'b1 || err !== 3'b000) begin n_fail++; $display("FAIL rd_nolate: cnt %0d ready %b err %b want 0 1 000", count, ready, err); end
    q.delete(); m_err = 3'b000;
  endtask

  task automatic test_random();
    int busy, e_busy, k;
    logic [2:0] o;
    logic [7:0] v;
    for (int r = 0; r < 5; r++) begin
      do_reset();
      for (int i = 0; i < 60; i++) begin
        k = $urandom_range(0, 11);
        if (k < 4) o = 3'd5;
        else if (k == 4) o = 3'd6;
        else if (k == 5) o = 3'd7;
        else o = 3'((k - 6) % 5);
        v = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
        e_busy = m_busy(o);
        m_apply(o, v);
        drive(o, v, busy);
        n_cmp++; if (busy != e_busy) begin n_fail++; $display("FAIL rnd_busy op%0d: got %0d want %0d", o, busy, e_busy); end
        n_cmp++; if (top !== m_top() || count !== 3'(q.size())) begin n_fail++; $display("FAIL rnd_stack op%0d: top %0d cnt %0d want %0d %0d", o, top, count, m_top(), q.size()); end
        n_cmp++; if (err !== m_err || valid !== ~|m_err) begin n_fail++; $display("FAIL rnd_err op%0d: err %b valid %b want %b %b", o, err, valid, m_err, ~|m_err); end
        n_cmp++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_flags op%0d: empty %b full %b size %0d", o, empty, full, q.size()); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; apply = 1'b0; op = 3'd0; t_in = 8'd0; m_err = 3'b000;
    test_reset();
    test_sub();
    test_divmod();
    test_arith();
    test_ovf_udf();
    test_div0();
    test_rst_during_div();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
